// File: rtl/aes_keyex_multi_if.sv
// Key-load, round-key and shared S-box signals of the multi-length AES key expander.
interface aes_keyex_multi_if #(
  parameter int MAXNK = 8
);
  localparam int NRK_MAX = MAXNK + 7;

  logic [1:0]               i_klen;
  logic [255:0]             i_key;
  logic                     i_key_en;
  logic                     o_key_ok;
  logic [3:0]               o_nr;
  logic [128*NRK_MAX-1:0]   o_exkey;
  logic                     o_sbox_use;
  logic [31:0]              o_sbox_din;
  logic [31:0]              i_sbox_dout;

  modport slave (
    input  i_klen, i_key, i_key_en, i_sbox_dout,
    output o_key_ok, o_nr, o_exkey, o_sbox_use, o_sbox_din
  );

  modport master (
    output i_klen, i_key, i_key_en, i_sbox_dout,
    input  o_key_ok, o_nr, o_exkey, o_sbox_use, o_sbox_din
  );
endinterface

// File: rtl/aes_keyex_multi.sv
// Iterative AES-128/192/256 key expansion, one schedule word per cycle,
// using a borrowed combinational S-box port.
module aes_keyex_multi #(
  parameter int MAXNK = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  aes_keyex_multi_if.slave kx
);
  localparam int NRK_MAX = MAXNK + 7;
  localparam int NW      = 4 * NRK_MAX;
  localparam int IW      = $clog2(NW);
  localparam int unsigned NKU = MAXNK;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     w_q [NW];
  logic [31:0]     w_d [NW];
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      nk_q, nk_d;
  logic [3:0]      nr_q, nr_d;
  logic [3:0]      sub_q, sub_d;   // idx mod Nk, tracked incrementally
  logic [3:0]      rc_q, rc_d;     // idx div Nk, tracked incrementally

  logic [3:0]      nk_sel;
  logic            accept;
  logic            last;
  logic [31:0]     prev;
  logic [31:0]     temp;
  logic [7:0]      rcon;

  // Shared decode used by both the next-state and output logic
  always_comb begin
    unique case (kx.i_klen)
      2'b00:   nk_sel = 4'd4;
      2'b01:   nk_sel = 4'd6;
      default: nk_sel = 4'd8;
    endcase
    accept = kx.i_key_en && (kx.i_klen != 2'b11) && (int'(nk_sel) <= MAXNK);
    prev   = w_q[idx_q - IW'(1)];
    last   = (idx_q == IW'({nr_q, 2'b11}));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nk_q    <= '0;
      nr_q    <= '0;
      sub_q   <= '0;
      rc_q    <= '0;
      for (int unsigned i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      sub_q   <= sub_d;
      rc_q    <= rc_d;
      for (int unsigned i = 0; i < NW; i++) w_q[i] <= w_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept)                          state_d = RUN;
    else if ((state_q == RUN) && last)   state_d = DONE;
  end

  always_comb begin
    unique case (rc_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase

    if (sub_q == 4'd0)                           temp = kx.i_sbox_dout ^ {rcon, 24'h0};
    else if ((nk_q == 4'd8) && (sub_q == 4'd4))  temp = kx.i_sbox_dout;
    else                                         temp = prev;

    for (int unsigned i = 0; i < NW; i++) w_d[i] = w_q[i];
    idx_d = idx_q;
    nk_d  = nk_q;
    nr_d  = nr_q;
    sub_d = sub_q;
    rc_d  = rc_q;

    if (accept) begin
      for (int unsigned i = 0; i < NW; i++) w_d[i] = '0;
      for (int unsigned i = 0; i < NKU; i++)
        if (4'(i) < nk_sel) w_d[i] = kx.i_key[255-32*i -: 32];
      nk_d  = nk_sel;
      nr_d  = nk_sel + 4'd6;
      idx_d = IW'(nk_sel);
      sub_d = '0;
      rc_d  = 4'd1;
    end else if (state_q == RUN) begin
      w_d[idx_q] = w_q[idx_q - IW'(nk_q)] ^ temp;
      idx_d      = idx_q + IW'(1);
      if (sub_q == nk_q - 4'd1) begin
        sub_d = '0;
        rc_d  = rc_q + 4'd1;
      end else begin
        sub_d = sub_q + 4'd1;
      end
    end
  end

  always_comb begin
    kx.o_sbox_use = (state_q == RUN);
    kx.o_key_ok   = (state_q == DONE);
    kx.o_nr       = nr_q;
    kx.o_sbox_din = '0;
    if (state_q == RUN)
      kx.o_sbox_din = (sub_q == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
    // Word w[4r] sits in the most significant 32 bits of round-key slice r
    kx.o_exkey = '0;
    for (int unsigned r = 0; r < NRK_MAX; r++)
      for (int unsigned j = 0; j < 4; j++)
        kx.o_exkey[128*r + 32*(3-j) +: 32] = w_q[4*r + j];
  end
endmodule

// File: tb/tb_aes_keyex_multi.sv
// Directed bench for aes_keyex_multi (MAXNK=8 and MAXNK=6) against a FIPS-197 style model.
module tb_aes_keyex_multi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_keyex_multi_if #(.MAXNK(8)) kx8 ();
  aes_keyex_multi_if #(.MAXNK(6)) kx6 ();

  aes_keyex_multi #(.MAXNK(8)) dut8 (.i_clk(clk), .i_rst(rst), .kx(kx8));
  aes_keyex_multi #(.MAXNK(6)) dut6 (.i_clk(clk), .i_rst(rst), .kx(kx6));

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] p   = x;
    logic [7:0] e   = 8'd254;
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) inv = gf_mul(inv, p);
      p = gf_mul(p, p);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  assign kx8.i_sbox_dout = sub_word(kx8.o_sbox_din);
  assign kx6.i_sbox_dout = sub_word(kx6.o_sbox_din);

  function automatic logic [1919:0] expand(input logic [1:0] klen, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [1919:0] v;
    int nk, nr;
    nk = (klen == 2'b00) ? 4 : (klen == 2'b01) ? 6 : 8;
    nr = nk + 6;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int k = 1; k < i/nk; k++) rc = xtime(rc);
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    v = '0;
    for (int i = 0; i < 60; i++) v[128*(i/4) + 32*(3-i%4) +: 32] = w[i];
    return v;
  endfunction

  function automatic logic [31:0] kw(input logic [1919:0] v, input int i);
    return v[128*(i/4) + 32*(3-i%4) +: 32];
  endfunction

  // Model state, index 0 = MAXNK 8 instance, 1 = MAXNK 6 instance
  logic          m_ok  [2];
  logic          m_run [2];
  logic [3:0]    m_nr  [2];
  int            m_cnt [2];
  logic [1919:0] m_key [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ok[d] = 0; m_run[d] = 0; m_nr[d] = 0; m_cnt[d] = 0; m_key[d] = '0;
    end
  end

  task automatic model_step(input int d, input logic en, input logic [1:0] klen,
                            input logic [255:0] key, input int maxnk);
    int nk;
    nk = (klen == 2'b00) ? 4 : (klen == 2'b01) ? 6 : 8;
    if (rst) begin
      m_ok[d] = 0; m_run[d] = 0; m_nr[d] = 0; m_cnt[d] = 0; m_key[d] = '0;
    end else if (en && klen != 2'b11 && nk <= maxnk) begin
      m_ok[d]  = 0;
      m_run[d] = 1;
      m_nr[d]  = 4'(nk + 6);
      m_cnt[d] = 4*(nk + 7) - nk;
      m_key[d] = expand(klen, key);
    end else if (m_run[d]) begin
      m_cnt[d] = m_cnt[d] - 1;
      if (m_cnt[d] == 0) begin
        m_run[d] = 0;
        m_ok[d]  = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, kx8.i_key_en, kx8.i_klen, kx8.i_key, 8);
    model_step(1, kx6.i_key_en, kx6.i_klen, kx6.i_key, 6);
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_key(input string name, input logic [1919:0] act, input logic [1919:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int r = 0; r < 15; r++)
        if (act[128*r +: 128] !== exp[128*r +: 128]) begin
          $display("FAIL %s slice %0d: got %h expected %h", name, r, act[128*r +: 128], exp[128*r +: 128]);
          break;
        end
    end
  endtask

  task automatic cmp(input int d, input string tag, input logic ok, input logic [3:0] nr,
                     input logic use_, input logic [31:0] din, input logic [1919:0] ex, input int nrk);
    logic [1919:0] ones = '1;
    logic [1919:0] mask;
    mask = ~(ones << (128*nrk));
    chk32({tag, ".nr"}, 32'(nr), 32'(m_nr[d]));
    if (m_run[d]) begin
      chk32({tag, ".key_ok_run"}, 32'(ok), 32'd0);
      chk32({tag, ".sbox_use_run"}, 32'(use_), 32'd1);
    end else begin
      chk32({tag, ".key_ok"}, 32'(ok), 32'(m_ok[d]));
      chk32({tag, ".sbox_use"}, 32'(use_), 32'd0);
      chk32({tag, ".sbox_din"}, din, 32'd0);
      chk_key({tag, ".exkey"}, ex, m_key[d] & mask);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, "dut8", kx8.o_key_ok, kx8.o_nr, kx8.o_sbox_use, kx8.o_sbox_din, kx8.o_exkey, 15);
      cmp(1, "dut6", kx6.o_key_ok, kx6.o_nr, kx6.o_sbox_use, kx6.o_sbox_din, {256'b0, kx6.o_exkey}, 13);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load8(input logic [1:0] klen, input logic [255:0] key);
    kx8.i_klen = klen; kx8.i_key = key; kx8.i_key_en = 1'b1;
    @(posedge clk); #2;
    kx8.i_key_en = 1'b0;
  endtask

  task automatic load6(input logic [1:0] klen, input logic [255:0] key);
    kx6.i_klen = klen; kx6.i_key = key; kx6.i_key_en = 1'b1;
    @(posedge clk); #2;
    kx6.i_key_en = 1'b0;
  endtask

  task automatic wait_ok8(output int n, output int uses);
    n = 0;
    uses = int'(kx8.o_sbox_use);
    while (!kx8.o_key_ok && n < 200) begin
      @(posedge clk); #1;
      n++;
      uses += int'(kx8.o_sbox_use);
    end
    #1;
  endtask

  task automatic check_aes128_result(input string tag);
    chk32({tag, "_nr"}, 32'(kx8.o_nr), 32'd10);
    chk32({tag, "_rk10_w40"}, kx8.o_exkey[1280+96 +: 32], 32'hd014f9a8);
    chk32({tag, "_rk10_w41"}, kx8.o_exkey[1280+64 +: 32], 32'hc9ee2589);
    chk32({tag, "_rk10_w42"}, kx8.o_exkey[1280+32 +: 32], 32'he13f0cc8);
    chk32({tag, "_rk10_w43"}, kx8.o_exkey[1280 +: 32], 32'hb6630ca6);
    for (int i = 44; i < 60; i++)
      chk32($sformatf("%s_w%0d_zero", tag, i), kw(kx8.o_exkey, i), 32'h0);
  endtask

  int n, uses, n6;

  initial begin
    rst = 1'b1;
    kx8.i_klen = '0; kx8.i_key = '0; kx8.i_key_en = 1'b0;
    kx6.i_klen = '0; kx6.i_key = '0; kx6.i_key_en = 1'b0;

    // Pin the model to published FIPS-197 values
    chk32("sbox_53", 32'(sbox(8'h53)), 32'hed);
    chk32("sbox_00", 32'(sbox(8'h00)), 32'h63);
    chk32("model_128_w43", kw(expand(2'b00, K128), 43), 32'hb6630ca6);
    chk32("model_192_w51", kw(expand(2'b01, K192), 51), 32'h01002202);
    chk32("model_256_w59", kw(expand(2'b10, K256), 59), 32'h706c631e);

    @(posedge clk); #2;
    cmp_en = 1'b1;
    cyc(2);
    rst = 1'b0;

    chk32("reset_key_ok", 32'(kx8.o_key_ok), 32'd0);
    chk32("reset_nr", 32'(kx8.o_nr), 32'd0);
    chk32("reset_sbox_use", 32'(kx8.o_sbox_use), 32'd0);
    chk_key("reset_exkey", kx8.o_exkey, '0);

    // AES-128
    load8(2'b00, K128);
    wait_ok8(n, uses);
    chk32("lat_128", 32'(n), 32'd40);
    chk32("use_128", 32'(uses), 32'd40);
    check_aes128_result("aes128");

    // Reserved key length while DONE
    load8(2'b11, K256);
    cyc(3);
    chk32("illegal11_key_ok", 32'(kx8.o_key_ok), 32'd1);
    chk_key("illegal11_exkey", kx8.o_exkey, expand(2'b00, K128));

    // AES-192
    load8(2'b01, K192);
    wait_ok8(n, uses);
    chk32("lat_192", 32'(n), 32'd46);
    chk32("nr_192", 32'(kx8.o_nr), 32'd12);
    chk32("w51_192", kw(kx8.o_exkey, 51), 32'h01002202);

    // AES-256
    load8(2'b10, K256);
    wait_ok8(n, uses);
    chk32("lat_256", 32'(n), 32'd52);
    chk32("use_256", 32'(uses), 32'd52);
    chk32("nr_256", 32'(kx8.o_nr), 32'd14);
    chk32("w59_256", kw(kx8.o_exkey, 59), 32'h706c631e);

    // Restart mid-run with the AES-128 key
    load8(2'b10, K256);
    cyc(19);
    chk32("restart_busy", 32'(kx8.o_key_ok), 32'd0);
    load8(2'b00, K128);
    wait_ok8(n, uses);
    chk32("lat_restart", 32'(n), 32'd40);
    check_aes128_result("restart");

    // MAXNK=6 instance: 192 accepted, 256 rejected
    load6(2'b01, K192);
    n6 = 0;
    while (!kx6.o_key_ok && n6 < 200) begin
      @(posedge clk); #1;
      n6++;
    end
    #1;
    chk32("lat_192_m6", 32'(n6), 32'd46);
    chk32("w51_192_m6", kw({256'b0, kx6.o_exkey}, 51), 32'h01002202);
    load6(2'b10, K256);
    cyc(3);
    chk32("illegal256_m6_key_ok", 32'(kx6.o_key_ok), 32'd1);
    chk32("illegal256_m6_nr", 32'(kx6.o_nr), 32'd12);
    chk_key("illegal256_m6_exkey", {256'b0, kx6.o_exkey}, expand(2'b01, K192));

    // Reset 15 cycles into an AES-192 run
    load8(2'b01, K192);
    cyc(14);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk32("midrst_key_ok", 32'(kx8.o_key_ok), 32'd0);
    chk32("midrst_nr", 32'(kx8.o_nr), 32'd0);
    chk32("midrst_sbox_use", 32'(kx8.o_sbox_use), 32'd0);
    chk32("midrst_sbox_din", kx8.o_sbox_din, 32'd0);
    chk_key("midrst_exkey", kx8.o_exkey, '0);
    load8(2'b00, K128);
    wait_ok8(n, uses);
    chk32("lat_after_rst", 32'(n), 32'd40);
    check_aes128_result("after_rst");

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
